var_delay_line: RTL and testbench
=================================

Name: var_delay_line

Overview:
Runtime-programmable delay line for pixel and control streams. It is the parametrised successor of the fixed-depth DFF delay.
- Delays a DATA_WIDTH payload plus a valid flag by 1..MAX_DELAY enabled cycles.
- The delay is reloadable on the fly.
- Two enable-low modes are selectable: clear or hold.
- Output qualification masks stale stage contents while the pipe refills after reset, a clear or a delay change.
- Sits between the sprite/coordinate generators and the VGA pixel path to align streams with different latencies.

Parameters:
DATA_WIDTH, 8, payload width in bits
MAX_DELAY, 16, number of stages; legal range 1..MAX_DELAY for the delay
HOLD_MODE, 0, en_i low behaviour: 0 = clear all stages, 1 = freeze all stages
RST_DLY, 2, delay value loaded at reset; must be 1..MAX_DELAY
DLY_W (localparam), $clog2(MAX_DELAY+1), delay port width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en_i  input  1  shift enable
data_i  input  DATA_WIDTH  payload in
valid_i  input  1  payload qualifier in
dly_load_i  input  1  load dly_i as the new delay at this edge
dly_i  input  DLY_W  requested delay
data_o  output  DATA_WIDTH  delayed payload; 0 while not in RUN
valid_o  output  1  delayed qualifier; 0 while not in RUN
ready_o  output  1  1 when in RUN (pipe filled to the current delay)
dly_o  output  DLY_W  delay currently in effect (dly_q)
range_err_o  output  1  sticky: last load request was out of range

Behaviour:
Reset (rst_n=0, asynchronous):
- All stage data and valid bits = 0.
- cnt = 0, state = FILL, dly_q = RST_DLY.
- range_err_o = 0; data_o = 0, valid_o = 0, ready_o = 0.

Stages and output path:
- stage[0..MAX_DELAY-1] are registers holding data and a valid bit.
- On an edge with en_i=1: stage[0] <= {valid_i, data_i}; stage[k] <= stage[k-1].
- Outputs are a mux of registered stages only. There is no combinational path from data_i or valid_i.
- Latency: a sample captured at enabled edge E0 appears on data_o after the dly_q-th enabled edge counting E0, i.e. it is held in stage[dly_q-1].
- With continuous en_i and dly_q=D, the output lags the input by exactly D cycles.

en_i=0 at an edge:
- HOLD_MODE=0: all stages cleared to 0, cnt <= 0, state <= FILL.
- HOLD_MODE=1: stages and cnt frozen; state unchanged; outputs keep their values.

State machine (FILL, RUN):
- FILL: data_o=0, valid_o=0, ready_o=0. Each enabled edge increments cnt, saturating at MAX_DELAY.
- FILL -> RUN at the edge where cnt+1 == dly_q with en_i=1.
- RUN: data_o = stage[dly_q-1].data, valid_o = stage[dly_q-1].valid, ready_o=1.
- RUN -> FILL only on a delay load or a HOLD_MODE=0 clear.

Delay load (dly_load_i=1 at an edge):
- dly_q <= clamp(dly_i): 0 -> 1, values > MAX_DELAY -> MAX_DELAY.
- range_err_o <= 1 if clamped, else 0.
- state <= FILL. Stage contents are NOT cleared.
- If en_i=1 on the same edge: the shift occurs and that edge counts, so cnt <= 1. If the new dly_q == 1, state goes directly to RUN.
- If en_i=0 on the same edge with HOLD_MODE=0: the clear happens, cnt <= 0, and the new dly_q is still loaded.
- If en_i=0 with HOLD_MODE=1: cnt <= 0, stages frozen.
- A load of the same value as dly_q still restarts the fill.

Other rules:
- Back-to-back loads: the last one wins; each restarts the fill.
- rst_n assertion mid-operation overrides everything immediately.
- dly_o always reflects dly_q.

Test Plan:
1. Reset, RST_DLY=2, en_i=1 constant, data_i = 1,2,3,... with valid_i=1 -> ready_o rises after edge 2; data_o shows 1 in the cycle after edge 2, then 2,3,... every cycle; valid_o=1 throughout.
2. Running at D=2, pulse dly_load_i with dly_i=5 -> ready_o and valid_o drop for 4 cycles; data_o = 0 during FILL; afterwards data_o equals the input from 5 cycles earlier.
3. dly_i=0 load -> dly_o=1, range_err_o=1; then dly_i=MAX_DELAY+3 (e.g. 19) -> dly_o=16, range_err_o=1; then dly_i=4 -> range_err_o=0.
4. HOLD_MODE=0, D=3, deassert en_i for 2 cycles mid-stream -> outputs 0 and ready_o=0 from the next edge; after re-enable, 3 enabled edges are needed before ready_o=1 with fresh data.
5. HOLD_MODE=1, D=3, deassert en_i for 4 cycles -> data_o, valid_o and ready_o frozen; after re-enable the sequence continues with no gap or loss.
6. Assert rst_n=0 asynchronously between edges in RUN -> all outputs 0 immediately; dly_o=RST_DLY; the refill is identical to scenario 1.

Source files
------------

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line: payload + valid delayed by 1..MAX_DELAY enabled cycles,
// with output qualification while the pipe refills after reset, clear or delay reload.

module vdl_stage #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         shift,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q <= '0;
      else if (shift) q <= d;
      else if (clr)   q <= '0;
   end
endmodule

module var_delay_line #(
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_DELAY  = 16,
   parameter  int HOLD_MODE  = 0,
   parameter  int RST_DLY    = 2,
   localparam int DLY_W      = $clog2(MAX_DELAY + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   input  logic                  dly_load_i,
   input  logic [DLY_W-1:0]      dly_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  ready_o,
   output logic [DLY_W-1:0]      dly_o,
   output logic                  range_err_o
);
   typedef struct packed {
      logic                  vld;
      logic [DATA_WIDTH-1:0] data;
   } stage_t;

   typedef enum logic {FILL, RUN} state_t;

   localparam int SW = DATA_WIDTH + 1;
   localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);

   stage_t [MAX_DELAY-1:0] stg, stg_d;
   state_t                 state, state_nx;
   logic [DLY_W-1:0]       cnt, cnt_nx, dly_q, dly_cl;
   logic [DLY_W:0]         cnt_inc;
   logic                   range_err, clamped, clr;

   assign clr = !en_i && (HOLD_MODE == 0);

   always_comb begin
      stg_d[0] = '{vld: valid_i, data: data_i};
      for (int k = 1; k < MAX_DELAY; k++) stg_d[k] = stg[k-1];
   end

   for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stg
      vdl_stage #(.W(SW)) u_stg (
         .clk   (clk),
         .rst_n (rst_n),
         .shift (en_i),
         .clr   (clr),
         .d     (stg_d[k]),
         .q     (stg[k])
      );
   end

   always_comb begin
      dly_cl  = dly_i;
      clamped = 1'b0;
      if (dly_i == '0) begin
         dly_cl  = DLY_W'(1);
         clamped = 1'b1;
      end else if (dly_i > MAX_D) begin
         dly_cl  = MAX_D;
         clamped = 1'b1;
      end
   end

   assign cnt_inc = {1'b0, cnt} + 1'b1;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (en_i) begin
         if (state == FILL) begin
            cnt_nx = (cnt == MAX_D) ? cnt : cnt_inc[DLY_W-1:0];
            if (cnt_inc == {1'b0, dly_q}) state_nx = RUN;
         end
      end else if (HOLD_MODE == 0) begin
         cnt_nx   = '0;
         state_nx = FILL;
      end
      // A load restarts the fill; an enabled load edge already counts as the first shift.
      if (dly_load_i) begin
         cnt_nx   = en_i ? DLY_W'(1) : '0;
         state_nx = (en_i && dly_cl == DLY_W'(1)) ? RUN : FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         cnt       <= '0;
         dly_q     <= DLY_W'(RST_DLY);
         range_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (dly_load_i) begin
            dly_q     <= dly_cl;
            range_err <= clamped;
         end
      end
   end

   always_comb begin
      data_o  = '0;
      valid_o = 1'b0;
      for (int k = 0; k < MAX_DELAY; k++) begin
         if (state == RUN && dly_q == DLY_W'(k + 1)) begin
            data_o  = stg[k].data;
            valid_o = stg[k].vld;
         end
      end
   end

   assign ready_o     = (state == RUN);
   assign dly_o       = dly_q;
   assign range_err_o = range_err;
endmodule

// File: tb/tb_var_delay_line.sv
// Bench for var_delay_line: clear-mode and hold-mode instances driven by one stimulus,
// checked every cycle against a sample-history model plus directed literal checks.

module tb_var_delay_line;
   localparam int DW   = 8;
   localparam int MD   = 16;
   localparam int RD   = 2;
   localparam int DLYW = $clog2(MD + 1);

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            en_i = 1'b0, valid_i = 1'b0, dly_load_i = 1'b0;
   logic [DW-1:0]   data_i = '0;
   logic [DLYW-1:0] dly_i = '0;

   logic [1:0][DW-1:0]   data_o;
   logic [1:0][DLYW-1:0] dly_o;
   logic [1:0]           valid_o, ready_o, range_err_o;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   var_delay_line #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .HOLD_MODE(0), .RST_DLY(RD)) u_clr (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
      .dly_load_i(dly_load_i), .dly_i(dly_i), .data_o(data_o[0]), .valid_o(valid_o[0]),
      .ready_o(ready_o[0]), .dly_o(dly_o[0]), .range_err_o(range_err_o[0]));

   var_delay_line #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .HOLD_MODE(1), .RST_DLY(RD)) u_hold (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
      .dly_load_i(dly_load_i), .dly_i(dly_i), .data_o(data_o[1]), .valid_o(valid_o[1]),
      .ready_o(ready_o[1]), .dly_o(dly_o[1]), .range_err_o(range_err_o[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Model: history of samples taken on enabled edges (index 0 = newest), and the number
   // of enabled edges since the last restart; output is qualified once that reaches the delay.
   logic [DW-1:0] mh [2][MD];
   logic          mv [2][MD];
   int            mfill [2];
   int            mdly [2];
   logic          merr [2];

   always @(posedge clk or negedge rst_n) begin
      int r;
      for (int h = 0; h < 2; h++) begin
         if (!rst_n) begin
            for (int k = 0; k < MD; k++) begin mh[h][k] = '0; mv[h][k] = 1'b0; end
            mfill[h] = 0;
            mdly[h]  = RD;
            merr[h]  = 1'b0;
         end else begin
            if (en_i) begin
               for (int k = MD - 1; k > 0; k--) begin mh[h][k] = mh[h][k-1]; mv[h][k] = mv[h][k-1]; end
               mh[h][0] = data_i;
               mv[h][0] = valid_i;
               if (mfill[h] < 1000) mfill[h]++;
            end else if (h == 0) begin
               for (int k = 0; k < MD; k++) begin mh[h][k] = '0; mv[h][k] = 1'b0; end
               mfill[h] = 0;
            end
            if (dly_load_i) begin
               r        = int'(dly_i);
               merr[h]  = (r == 0) || (r > MD);
               mdly[h]  = (r == 0) ? 1 : (r > MD) ? MD : r;
               mfill[h] = en_i ? 1 : 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic rdy;
      for (int h = 0; h < 2; h++) begin
         rdy = (mfill[h] >= mdly[h]);
         chk($sformatf("m%0d_ready", h), 32'(ready_o[h]), 32'(rdy));
         chk($sformatf("m%0d_data", h), 32'(data_o[h]), rdy ? 32'(mh[h][mdly[h]-1]) : 32'd0);
         chk($sformatf("m%0d_valid", h), 32'(valid_o[h]), rdy ? 32'(mv[h][mdly[h]-1]) : 32'd0);
         chk($sformatf("m%0d_dly", h), 32'(dly_o[h]), 32'(mdly[h]));
         chk($sformatf("m%0d_rerr", h), 32'(range_err_o[h]), 32'(merr[h]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      data_i = data_i + 1'b1;
   endtask

   task automatic load(input int v);
      dly_load_i = 1'b1;
      dly_i      = DLYW'(v);
      tick();
      dly_load_i = 1'b0;
   endtask

   initial begin
      int dl;
      en_i = 1'b1; valid_i = 1'b1; data_i = 8'd1;
      #8;
      chk("rst_ready", 32'(ready_o[0]), 0);
      chk("rst_dly", 32'(dly_o[0]), RD);
      #4 rst_n = 1'b1;

      // first fill at the reset delay
      tick();
      @(negedge clk); chk("fill1_ready", 32'(ready_o[0]), 0);
      tick();
      @(negedge clk);
      chk("run_data1", 32'(data_o[0]), 1);
      chk("run_ready", 32'(ready_o[0]), 1);
      chk("run_valid", 32'(valid_o[0]), 1);
      tick();
      @(negedge clk); chk("run_data2", 32'(data_o[0]), 2);

      // reload to 5: four FILL cycles, then the sample from the load edge
      repeat (3) tick();
      dl = int'(data_i);
      load(5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("reload_fill", 32'(ready_o[0]), 0);
         tick();
      end
      @(negedge clk);
      chk("reload_ready", 32'(ready_o[0]), 1);
      chk("reload_data", 32'(data_o[0]), dl);
      chk("reload_dly", 32'(dly_o[0]), 5);

      // clamping
      load(0);
      @(negedge clk); chk("clamp0_dly", 32'(dly_o[0]), 1); chk("clamp0_err", 32'(range_err_o[0]), 1);
      load(MD + 3);
      @(negedge clk); chk("clampmax_dly", 32'(dly_o[0]), MD); chk("clampmax_err", 32'(range_err_o[0]), 1);
      load(4);
      @(negedge clk); chk("inrange_dly", 32'(dly_o[0]), 4); chk("inrange_err", 32'(range_err_o[0]), 0);

      // enable low at D=3: clear vs hold
      load(3);
      repeat (6) tick();
      en_i = 1'b0;
      tick();
      @(negedge clk);
      chk("clr_ready", 32'(ready_o[0]), 0);
      chk("clr_data", 32'(data_o[0]), 0);
      chk("hold_ready", 32'(ready_o[1]), 1);
      repeat (3) tick();
      en_i = 1'b1;
      tick(); tick();
      @(negedge clk); chk("refill2_ready", 32'(ready_o[0]), 0);
      tick();
      @(negedge clk); chk("refill3_ready", 32'(ready_o[0]), 1);

      // asynchronous reset between edges while running
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", 32'(data_o[0]), 0);
      chk("arst_ready", 32'(ready_o[0]), 0);
      chk("arst_valid", 32'(valid_o[0]), 0);
      chk("arst_dly", 32'(dly_o[0]), RD);
      chk("arst_hold_ready", 32'(ready_o[1]), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) tick();

      // randomized traffic
      repeat (3000) begin
         en_i       = ($urandom_range(0, 9) != 0);
         dly_load_i = ($urandom_range(0, 24) == 0);
         dly_i      = DLYW'($urandom_range(0, 31));
         data_i     = DW'($urandom);
         valid_i    = 1'($urandom);
         @(posedge clk);
         #1;
      end
      dly_load_i = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
